// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A horizontal counter (h) and a
// vertical counter (v) step once per qualified pixel strobe. Every output is
// a register loaded with the decode of the current (h, v) on every clock, so
// all outputs lag the counters by exactly one clock and stay mutually aligned.
//
// Line/frame ordering: active, front porch, sync, back porch. Counter value 0
// is the first visible pixel/line.
//
// Advance qualifier: adv = i_pix_stb & i_en. i_pix_stb is a plain level
// strobe, not a valid/ready handshake; there is no back-pressure, and a
// strobe on consecutive clocks advances on every one of them. With i_en low
// the counters freeze, the level outputs hold and no pulses are produced.
//
// Optional build macro:
//   VGA_TIMING_FRAME_CNT_EN - builds the o_frame counter (wraps mod 2^F_W,
//                             steps on the same clock o_screenend is loaded
//                             high). Undefined: o_frame is tied to 0.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_pix_stb    pixel-rate strobe
//   i_en         run enable (low = freeze)
//   o_hs, o_vs   sync outputs, asserted level HS_POL / VS_POL
//   o_active     current pixel is visible
//   o_blanking   inverse of o_active
//   o_line_end   1-clock pulse after the last pixel of each line
//   o_screenend  1-clock pulse after the last pixel of the frame
//   o_animate    1-clock pulse after the last visible pixel of the frame
//   o_x, o_y     visible position (0 outside the visible region)
//   o_frame      frame counter
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int F_W      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_stb,
    input  logic           i_en,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_active,
    output logic           o_blanking,
    output logic           o_line_end,
    output logic           o_screenend,
    output logic           o_animate,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic [F_W-1:0] o_frame
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_STOP  = VS_START + V_SYNC;

    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_ACT_LAST = Y_W'(V_ACTIVE - 1);

    // Counter widths must hold the full totals; anything else would silently
    // wrap early and corrupt the raster.
    if (H_TOTAL > (2 ** X_W)) begin : g_bad_x_w
        $error("vga_timing_gen: H_TOTAL (%0d) exceeds 2^X_W", H_TOTAL);
    end
    if (V_TOTAL > (2 ** Y_W)) begin : g_bad_y_w
        $error("vga_timing_gen: V_TOTAL (%0d) exceeds 2^Y_W", V_TOTAL);
    end

    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic           adv;
    logic           h_last;
    logic           v_last;

    assign adv    = i_pix_stb & i_en;
    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);

    // -----------------------------------------------------------------------
    // Raster counters
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (adv) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode of the current position. Compares are done on the zero-extended
    // counters against the integer boundaries so nothing is truncated.
    // -----------------------------------------------------------------------
    logic h_vis;
    logic v_vis;
    logic hs_d;
    logic vs_d;

    always_comb begin
        h_vis = (int'(h) < H_ACTIVE);
        v_vis = (int'(v) < V_ACTIVE);
        hs_d  = ((int'(h) >= HS_START) && (int'(h) < HS_STOP)) ? HS_POL : ~HS_POL;
        vs_d  = ((int'(v) >= VS_START) && (int'(v) < VS_STOP)) ? VS_POL : ~VS_POL;
    end

    // -----------------------------------------------------------------------
    // Output registers. Levels reload every clock; pulses only on adv, so a
    // frozen generator produces no pulses.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hs        <= ~HS_POL;
            o_vs        <= ~VS_POL;
            o_active    <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_line_end  <= 1'b0;
            o_screenend <= 1'b0;
            o_animate   <= 1'b0;
        end else begin
            o_hs        <= hs_d;
            o_vs        <= vs_d;
            o_active    <= h_vis & v_vis;
            o_x         <= h_vis ? h : '0;
            o_y         <= v_vis ? v : '0;
            o_line_end  <= adv & h_last;
            o_screenend <= adv & h_last & v_last;
            o_animate   <= adv & (h == H_ACT_LAST) & (v == V_ACT_LAST);
        end
    end

    // Derived from the registered o_active, so it is also 1 during reset.
    assign o_blanking = ~o_active;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [F_W-1:0] frame_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_q <= '0;
        end else if (adv & h_last & v_last) begin
            frame_q <= frame_q + 1'b1;
        end
    end

    assign o_frame = frame_q;
`else
    assign o_frame = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator, successor to the fixed 640x480 display timing block.
- Produces the following from a pixel strobe:
  - hsync and vsync with configurable polarity
  - active, blanking and pixel coordinates
  - screen-end and animate pulses
  - an optional frame counter
- Sits between the clock/strobe divider and the pixel/framebuffer logic.
- Adds a run/freeze enable and a line-end pulse.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync width, in lines
- V_BP, 33, vertical back porch, in lines
- HS_POL, 0, asserted level of o_hs (0 = active-low)
- VS_POL, 0, asserted level of o_vs (0 = active-low)
- X_W, 10, width of o_x and of the horizontal counter; H_TOTAL must be at most 2^X_W
- Y_W, 10, width of o_y and of the vertical counter; V_TOTAL must be at most 2^Y_W
- F_W, 8, frame counter width

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel-rate strobe; counters advance only on cycles where it is high
- i_en  in  1  run enable; when low, counters freeze
- o_hs  out  1  horizontal sync, level set by HS_POL
- o_vs  out  1  vertical sync, level set by VS_POL
- o_active  out  1  current pixel is in the visible region
- o_blanking  out  1  inverse of o_active
- o_line_end  out  1  one-clock pulse on the last pixel of each line
- o_screenend  out  1  one-clock pulse on the last pixel of the frame
- o_animate  out  1  one-clock pulse on the last active pixel of the frame
- o_x  out  X_W  horizontal position
- o_y  out  Y_W  vertical position
- o_frame  out  F_W  frame counter

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line ordering: active, then front porch, sync, back porch. Counter value 0 is the first visible pixel/line.
- Advance condition: adv = i_pix_stb & i_en.
- Horizontal counter h:
  - On adv, h = (h == H_TOTAL-1) ? 0 : h+1.
- Vertical counter v:
  - Advances only on adv with h == H_TOTAL-1: v = (v == V_TOTAL-1) ? 0 : v+1.
- Decode and registration:
  - All outputs are registered, decoded from the current h/v every clock regardless of adv.
  - Outputs therefore lag the counters by exactly 1 clock.
  - o_x/o_y carry the same lag, so they stay aligned with the sync and active outputs.
- o_active = (h < H_ACTIVE) & (v < V_ACTIVE).
- o_blanking = ~o_active at all times, including during reset.
- o_hs = HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; ~HS_POL otherwise.
- o_vs = VS_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; ~VS_POL otherwise.
- o_x = h when h < H_ACTIVE, else 0. o_y = v when v < V_ACTIVE, else 0.
- Pulses (each one clock wide, registered 1 clock after the qualifying adv):
  - o_line_end: adv & h == H_TOTAL-1
  - o_screenend: adv & h == H_TOTAL-1 & v == V_TOTAL-1
  - o_animate: adv & h == H_ACTIVE-1 & v == V_ACTIVE-1
- Freeze (i_en low):
  - Counters hold.
  - Level outputs hold their decoded values.
  - No pulses are generated.
  - Resuming continues from the held position with no skipped pixel.
- i_pix_stb high on consecutive clocks: the counter advances on every such clock; no rate check is made.
- Reset, asynchronous and immediate, including mid-frame:
  - h = 0, v = 0, o_frame = 0
  - o_hs = ~HS_POL, o_vs = ~VS_POL
  - o_active = 0, o_blanking = 1
  - o_x = 0, o_y = 0
  - all pulses 0
- After reset release: the first clock edge loads the decode of (0,0), giving o_active = 1. This happens even with no strobe.
- Widths: counter compares are done at X_W/Y_W bits with no truncation. A parameter set with H_TOTAL > 2^X_W (or V_TOTAL > 2^Y_W) is illegal; simulation reports $error at time 0.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: o_frame increments, wrapping mod 2^F_W, in the same clock that o_screenend is registered high.
- Undefined: o_frame is tied to 0 and no frame counter register is built.

Test Plan:
- Setup: small parameters H 8/2/3/3 (H_TOTAL 16) and V 4/1/2/1 (V_TOTAL 8); i_pix_stb every 2nd clock; i_en = 1.
  - Reset then run one line -> o_active high for x = 0..7, o_hs = 0 for h = 10..12, o_line_end pulses once per 16 strobes.
  - Run a full frame -> o_vs = 0 for v = 5..6; o_animate exactly 1 pulse at (7,3); o_screenend 1 pulse at (15,7); next strobe gives o_x = 0, o_y = 0.
- Same setup, HS_POL = 1, VS_POL = 1 -> sync pulses are high-true; idle level is 0, including during reset.
- Drop i_en for 20 clocks at h = 5 -> o_x holds 5 and no pulses occur; after re-enable, the next strobe gives o_x = 6.
- Assert i_rst_n low mid-frame at (6,2) -> outputs reach reset values immediately, with no clock edge needed.
  - After release: the first clock gives o_active = 1 and o_x = o_y = 0.
  - With the macro defined, o_frame = 0.
- Macro defined, F_W = 2, run 5 frames -> o_frame reads 1, 2, 3, 0, 1. Macro undefined -> o_frame stays 0.
